// File: rtl/ota_stim_pkg.sv
// Shared encodings for the OTA stimulus generator: run modes and sequencer states.

package ota_stim_pkg;

    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_RAMP = 2'd1;
    localparam logic [1:0] MODE_STEP = 2'd2;
    localparam logic [1:0] MODE_TRI  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StUp,
        StDown,
        StStepHi,
        StStepLo
    } state_e;

endpackage

// File: rtl/sdm1_mod.sv
// First-order sigma-delta modulator: the carry out of a WIDTH-bit phase accumulator
// is the bitstream, so long-run duty equals code / 2^WIDTH.

module sdm1_mod #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] code,
    output logic             dac_out
);

    logic [WIDTH-1:0] r_acc;
    logic             r_dac;
    logic [WIDTH:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, code};
    assign dac_out = r_dac;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_dac <= 1'b0;
        end else begin
            r_acc <= w_sum[WIDTH-1:0];
            r_dac <= w_sum[WIDTH];
        end
    end

endmodule

// File: rtl/ota_stim_sdm.sv
// Stimulus sequencer (hold / ramp / step / triangle) feeding a sigma-delta DAC that
// drives the OTA PLUS input through an off-chip RC filter.

module ota_stim_sdm
    import ota_stim_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_target,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] code_out,
    output logic             dac_out
);

    state_e           r_state;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_target;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_code;
    logic             r_done;
    logic             r_hold_pend;

    logic             w_accept;
    logic [1:0]       w_mode;
    logic [WIDTH-1:0] w_target;
    logic [DIV_W-1:0] w_div;
    logic             w_dwell_end;
    logic [WIDTH-1:0] w_code_inc;
    logic [WIDTH-1:0] w_code_dec;
    logic             w_up_turn;
    logic             w_down_turn;

    // A config offered alongside start in IDLE takes effect for that run.
    assign w_accept = cfg_valid && (r_state == StIdle);
    assign w_mode   = w_accept ? cfg_mode   : r_mode;
    assign w_target = w_accept ? cfg_target : r_target;
    assign w_div    = w_accept ? cfg_div    : r_div;

    assign w_dwell_end = (r_cnt == r_div);
    assign w_code_inc  = r_code + 1'b1;
    assign w_code_dec  = r_code - 1'b1;

    // Turn on the dwell that lands on the end code, or immediately if already there.
    assign w_up_turn   = (r_code == r_target) || (w_code_inc == r_target);
    assign w_down_turn = (r_code == '0) || (w_code_dec == '0);

    assign cfg_ready = (r_state == StIdle);
    assign busy      = (r_state != StIdle);
    assign done      = r_done;
    assign code_out  = r_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_mode      <= MODE_HOLD;
            r_target    <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_code      <= '0;
            r_done      <= 1'b0;
            r_hold_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mode   <= cfg_mode;
                r_target <= cfg_target;
                r_div    <= w_div;
            end
            if (abort) begin
                r_state     <= StIdle;
                r_cnt       <= '0;
                r_hold_pend <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_hold_pend <= 1'b0;
                        if (r_hold_pend) begin
                            r_done <= 1'b1;
                        end
                        if (start) begin
                            r_cnt <= '0;
                            case (w_mode)
                                MODE_HOLD: begin
                                    r_code      <= w_target;
                                    r_hold_pend <= 1'b1;
                                end
                                MODE_STEP: begin
                                    r_code  <= w_target;
                                    r_state <= StStepHi;
                                end
                                default: begin
                                    r_code  <= '0;
                                    r_state <= StUp;
                                end
                            endcase
                        end
                    end
                    StUp: begin
                        if (w_dwell_end) begin
                            r_cnt <= '0;
                            if (r_code != r_target) begin
                                r_code <= w_code_inc;
                            end
                            if (w_up_turn) begin
                                if (r_mode == MODE_TRI) begin
                                    r_state <= StDown;
                                end else begin
                                    r_state <= StIdle;
                                    r_done  <= 1'b1;
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    StDown: begin
                        if (w_dwell_end) begin
                            r_cnt <= '0;
                            if (r_code != '0) begin
                                r_code <= w_code_dec;
                            end
                            if (w_down_turn) begin
                                r_state <= StUp;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    StStepHi: begin
                        if (w_dwell_end) begin
                            r_cnt   <= '0;
                            r_code  <= '0;
                            r_state <= StStepLo;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    StStepLo: begin
                        if (w_dwell_end) begin
                            r_cnt   <= '0;
                            r_code  <= r_target;
                            r_state <= StStepHi;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    sdm1_mod #(
        .WIDTH (WIDTH)
    ) u_sdm (
        .clk     (clk),
        .rst     (rst),
        .code    (r_code),
        .dac_out (dac_out)
    );

endmodule

// File: doc/ota_stim_sdm.md
# ota_stim_sdm

Digital stimulus generator that sits directly upstream of the 5-transistor OTA analog macro. It produces a 1-bit first-order sigma-delta bitstream on a dedicated digital output. An off-chip RC low-pass turns that bitstream into the voltage on the OTA's PLUS input. A small sequencer turns the code into a hold level, ramp, square step or triangle, so OTA DC transfer, slew and settling can be characterised from the tile's digital pins alone.

## Interface
Parameters:
- WIDTH, 8: DAC code width; modulator resolution is 2^WIDTH.
- DIV_W, 8: width of the per-step dwell divider.

Ports:
- clk  in  1  sole clock; all state is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  high only in IDLE; a config is accepted on cycles where cfg_valid && cfg_ready.
- cfg_mode  in  2  0=HOLD, 1=RAMP, 2=STEP, 3=TRI.
- cfg_target  in  WIDTH  end or high code.
- cfg_div  in  DIV_W  dwell = cfg_div+1 cycles per code update.
- start  in  1  one-cycle pulse; begins a run from IDLE.
- abort  in  1  one-cycle pulse; ends any run.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle completion/period strobe.
- code_out  out  WIDTH  code currently being modulated.
- dac_out  out  1  sigma-delta bitstream that drives the RC filter to OTA PLUS.

## Operation
- Registers: mode, target and div are latched on acceptance; the accumulator acc is WIDTH bits; dwell counter; FSM.
- Modulator runs every cycle in every state: sum = {1'b0,acc} + {1'b0,code_out}, giving WIDTH+1 bits; acc <= sum[WIDTH-1:0]; dac_out <= sum[WIDTH].
- Long-run duty is code_out/2^WIDTH. code 0 gives a constant 0. The maximum code gives one low cycle per 2^WIDTH.
- FSM states:
  - IDLE
  - UP: code_out increments each dwell.
  - DOWN: code_out decrements each dwell.
  - STEP_HI, STEP_LO: code_out = target or 0, toggling each dwell.
- start in IDLE:
  - HOLD: code_out <= target, done pulses on the next cycle, state stays IDLE.
  - RAMP, TRI: code_out <= 0 and go to UP.
  - STEP: code_out <= target and go to STEP_HI.
- UP: when code_out == target at the end of a dwell:
  - RAMP: pulse done and go to IDLE, holding code_out at target.
  - TRI: go to DOWN.
- DOWN: when code_out == 0 at the end of a dwell, pulse done and go back to UP (TRI repeats indefinitely).
- STEP: done pulses on each STEP_LO to STEP_HI transition.
- Target 0 in RAMP: done after the first dwell with no increments. Target 0 in TRI: UP and DOWN alternate with code_out stuck at 0, and done pulses each period.
- abort in any state: IDLE next cycle; code_out is unchanged; no done pulse.
- The modulator keeps running in IDLE, so the OTA input holds its last level.
- Simultaneous events:
  - cfg accept and start in the same IDLE cycle: the run uses the new config.
  - abort together with start: abort wins and no run begins.
  - cfg_valid while busy: ignored, nothing latched.
  - start while busy: ignored.
- Reset mid-run: everything returns to reset values immediately (asynchronous). Latched config resets to mode=HOLD, target=0, div=0.

## Timing
- Reset values: cfg_ready=1, busy=0, done=0, code_out=0, dac_out=0, acc=0, FSM=IDLE.
- The start-accept edge is edge 0. code_out holds its initial value from edge 0, and busy is high from edge 0.
- code_out updates on edges (div+1), 2(div+1), and so on.
- dac_out lags code_out by one cycle: the sum uses the registered code_out.
- done is registered. It asserts for exactly one cycle, on the same edge that moves the FSM.
- cfg_ready = (state==IDLE), a registered-state decode with no combinational path from inputs.

## Structure
- Shared package ota_stim_pkg holds the mode encoding (MODE_HOLD/RAMP/STEP/TRI) and the FSM state enum.
- One sub-module, sdm1_mod: accumulator and dac_out register, inputs code and clk/rst.
- The sequencer and config registers are in ota_stim_sdm.

## Test plan
- Reset asserted mid-TRI with code_out=37 → the same cycle gives code_out=0, dac_out=0, busy=0, cfg_ready=1; after release, dac_out stays 0 for 100 cycles.
- HOLD, target=64, WIDTH=8 → done pulse at edge 1; over any 256 consecutive cycles dac_out is high exactly 64 times, with period-4 pattern 0001.
- RAMP, target=3, div=1 → code_out is 0,0,1,1,2,2,3 on edges 0..6; done is high only at edge 6, together with busy falling; code_out stays 3.
- TRI, target=2, div=0 → code_out sequence 0,1,2,1,0,1,2,… with done on each return to 0; abort at code 1 → IDLE next edge, code_out=1, no done.
- STEP, target=200, div=3 → code_out alternates 200 and 0 every 4 cycles; done on each 0→200 edge. cfg_valid while busy → cfg_ready=0 and nothing latched; start+abort in the same cycle → stays IDLE.
- cfg (RAMP, target=5) accepted in the same cycle as start → the run ramps to 5, not to the previously latched target.
